// File: rtl/secded_pkg.sv
// ---------------------------------------------------------------------------
// secded_pkg : shared constants and elaboration-time helpers for the SECDED codec
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package secded_pkg;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  // Smallest P with 2^P >= data_w + P + 1; scanning downward leaves the minimum.
  function automatic int p_w_for(input int data_w);
    int p;
    p = 0;
    for (int i = 30; i >= 1; i--) begin
      if ((1 << i) >= data_w + i + 1) p = i;
    end
    return p;
  endfunction

  function automatic bit is_pow2(input int pos);
    return (pos > 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Payload bit index carried at a (non power-of-two) code position.
  function automatic int data_idx(input int pos);
    int cnt;
    cnt = 0;
    for (int q = 3; q < pos; q++) begin
      if (!is_pow2(q)) cnt++;
    end
    return cnt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/secded_syndrome.sv
// ---------------------------------------------------------------------------
// secded_syndrome : Hamming syndrome and overall parity of one code word
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module secded_syndrome
  import secded_pkg::*;
#(
  parameter  int DATA_W = 11,
  localparam int P_W    = p_w_for(DATA_W),
  localparam int CODE_W = DATA_W + P_W + 1
) (
  input  logic [CODE_W-1:0] code,
  output logic [P_W-1:0]    syndrome,
  output logic              parity
);

  // Positions 1..CODE_W-1 whose index has bit j set; the overall bit is never covered.
  function automatic logic [CODE_W-1:0] cover_mask(input int j);
    logic [CODE_W-1:0] m;
    m = '0;
    for (int p = 1; p < CODE_W; p++) begin
      if (((p >> j) & 1) == 1) m = m | (CODE_W'(1) << (p - 1));
    end
    return m;
  endfunction

  for (genvar j = 0; j < P_W; j++) begin : g_syn
    localparam logic [CODE_W-1:0] MASK = cover_mask(j);
    assign syndrome[j] = ^(code & MASK);
  end

  assign parity = ^code;

endmodule

`default_nettype wire

// File: rtl/secded_stream_codec.sv
// ---------------------------------------------------------------------------
// secded_stream_codec : two-stage pipelined SECDED encoder/decoder, valid/ready
// Revision            : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module secded_stream_codec
  import secded_pkg::*;
#(
  parameter  int DATA_W = 11,
  parameter  int CNT_W  = 16,
  localparam int P_W    = p_w_for(DATA_W),
  localparam int CODE_W = DATA_W + P_W + 1,
  localparam int IDX_W  = P_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mode,
  input  logic [CODE_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_data,
  output logic              out_err,
  output logic              out_uncorr,
  output logic [IDX_W-1:0]  out_err_idx,
  input  logic              clear_cnt,
  output logic [CNT_W-1:0]  cnt_corr,
  output logic [CNT_W-1:0]  cnt_uncorr
);

  localparam logic [IDX_W-1:0] MAX_POS     = IDX_W'(CODE_W - 1);
  localparam logic [IDX_W-1:0] IDX_OVERALL = IDX_W'(CODE_W);

  logic              s1_valid_q, s1_valid_d, s1_mode_q, s1_mode_d, s1_par_q, s1_par_d;
  logic [DATA_W-1:0] s1_pay_q, s1_pay_d;
  logic [P_W-1:0]    s1_syn_q, s1_syn_d;
  logic              s2_valid_q, s2_valid_d, s2_err_q, s2_err_d, s2_uncorr_q, s2_uncorr_d;
  logic [CODE_W-1:0] s2_data_q, s2_data_d;
  logic [IDX_W-1:0]  s2_idx_q, s2_idx_d;
  logic [CNT_W-1:0]  cnt_corr_q, cnt_corr_d, cnt_uncorr_q, cnt_uncorr_d;

  logic              s1_en, s2_en, syn_in_range, fix;
  logic              res_err, res_uncorr;
  logic [IDX_W-1:0]  res_idx;
  logic [CODE_W-1:0] res_data, enc_word, syn_word, enc_code;
  logic [DATA_W-1:0] raw_pay, dec_pay;
  logic [P_W-1:0]    syn;
  logic              par;

  // Encode feeds the syndrome unit a word with zeroed parity slots; decode feeds the raw code.
  for (genvar p = 1; p < CODE_W; p++) begin : g_pos
    if (is_pow2(p)) begin : g_par
      assign enc_word[p-1] = 1'b0;
      assign enc_code[p-1] = s1_syn_q[$clog2(p)];
    end else begin : g_dat
      localparam int K = data_idx(p);
      assign enc_word[p-1] = in_data[K];
      assign raw_pay[K]    = in_data[p-1];
      assign enc_code[p-1] = s1_pay_q[K];
      assign dec_pay[K]    = s1_pay_q[K] ^ (fix && (s1_syn_q == P_W'(p)));
    end
  end
  assign enc_word[CODE_W-1] = 1'b0;
  assign enc_code[CODE_W-1] = s1_par_q ^ (^s1_syn_q);

  assign syn_word = (in_mode == MODE_DEC) ? in_data : enc_word;

  secded_syndrome #(.DATA_W(DATA_W)) u_syndrome (
    .code     (syn_word),
    .syndrome (syn),
    .parity   (par)
  );

  if (CODE_W - 1 == (1 << P_W) - 1) begin : g_full_range
    assign syn_in_range = 1'b1;
  end else begin : g_part_range
    assign syn_in_range = ({1'b0, s1_syn_q} <= MAX_POS);
  end

  always_comb begin
    res_err    = 1'b0;
    res_uncorr = 1'b0;
    res_idx    = '0;
    fix        = 1'b0;
    if (s1_mode_q == MODE_DEC) begin
      if (s1_syn_q == '0) begin
        if (s1_par_q) begin
          res_err = 1'b1;
          res_idx = IDX_OVERALL;
        end
      end else if (s1_par_q && syn_in_range) begin
        res_err = 1'b1;
        res_idx = {1'b0, s1_syn_q};
        fix     = 1'b1;
      end else begin
        res_err    = 1'b1;
        res_uncorr = 1'b1;
      end
    end
    res_data = (s1_mode_q == MODE_DEC) ? {{(CODE_W-DATA_W){1'b0}}, dec_pay} : enc_code;
  end

  assign s2_en    = ~s2_valid_q | out_ready;
  assign s1_en    = ~s1_valid_q | s2_en;
  assign in_ready = s1_en;

  always_comb begin
    s1_valid_d = s1_en ? in_valid : s1_valid_q;
    s1_mode_d  = s1_mode_q;
    s1_pay_d   = s1_pay_q;
    s1_syn_d   = s1_syn_q;
    s1_par_d   = s1_par_q;
    if (s1_en && in_valid) begin
      s1_mode_d = in_mode;
      s1_pay_d  = (in_mode == MODE_DEC) ? raw_pay : in_data[DATA_W-1:0];
      s1_syn_d  = syn;
      s1_par_d  = par;
    end
    s2_valid_d  = s2_en ? s1_valid_q : s2_valid_q;
    s2_data_d   = s2_data_q;
    s2_err_d    = s2_err_q;
    s2_uncorr_d = s2_uncorr_q;
    s2_idx_d    = s2_idx_q;
    if (s2_en && s1_valid_q) begin
      s2_data_d   = res_data;
      s2_err_d    = res_err;
      s2_uncorr_d = res_uncorr;
      s2_idx_d    = res_idx;
    end
  end

  // Statistics count results as they leave; encode beats never carry error flags.
  always_comb begin
    cnt_corr_d   = cnt_corr_q;
    cnt_uncorr_d = cnt_uncorr_q;
    if (s2_valid_q && out_ready) begin
      if (s2_err_q && !s2_uncorr_q && (cnt_corr_q != '1)) cnt_corr_d = cnt_corr_q + 1'b1;
      if (s2_uncorr_q && (cnt_uncorr_q != '1)) cnt_uncorr_d = cnt_uncorr_q + 1'b1;
    end
    if (clear_cnt) begin
      cnt_corr_d   = '0;
      cnt_uncorr_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_mode_q    <= 1'b0;
      s1_pay_q     <= '0;
      s1_syn_q     <= '0;
      s1_par_q     <= 1'b0;
      s2_valid_q   <= 1'b0;
      s2_data_q    <= '0;
      s2_err_q     <= 1'b0;
      s2_uncorr_q  <= 1'b0;
      s2_idx_q     <= '0;
      cnt_corr_q   <= '0;
      cnt_uncorr_q <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_mode_q    <= s1_mode_d;
      s1_pay_q     <= s1_pay_d;
      s1_syn_q     <= s1_syn_d;
      s1_par_q     <= s1_par_d;
      s2_valid_q   <= s2_valid_d;
      s2_data_q    <= s2_data_d;
      s2_err_q     <= s2_err_d;
      s2_uncorr_q  <= s2_uncorr_d;
      s2_idx_q     <= s2_idx_d;
      cnt_corr_q   <= cnt_corr_d;
      cnt_uncorr_q <= cnt_uncorr_d;
    end
  end

  assign out_valid   = s2_valid_q;
  assign out_data    = s2_data_q;
  assign out_err     = s2_err_q;
  assign out_uncorr  = s2_uncorr_q;
  assign out_err_idx = s2_idx_q;
  assign cnt_corr    = cnt_corr_q;
  assign cnt_uncorr  = cnt_uncorr_q;

endmodule

`default_nettype wire
